// File: rtl/posit_unpack_stage_pkg.sv
// Shared types, constants and helpers for the 64-bit posit unpack datapath.
package posit_types;

  typedef logic [63:0] posit64_t;
  typedef logic        sign_t;

  localparam posit64_t POSIT64_ZERO = 64'h0;
  localparam posit64_t POSIT64_NAR  = 64'h8000_0000_0000_0000;

  localparam int unsigned UNP_SCALE_W = 16;
  localparam int unsigned UNP_FRAC_W  = 59;

  // Default-configuration view of one unpacked operand.
  typedef struct packed {
    logic                          sign;
    logic signed [UNP_SCALE_W-1:0] scale;
    logic [UNP_FRAC_W:0]           sig;
    logic                          sticky;
    logic                          zero;
    logic                          nar;
  } unpacked64_t;

  function automatic logic signed [63:0] posit_scale(input logic signed [63:0] regime,
                                                     input logic signed [63:0] exponent,
                                                     input int unsigned       es);
    return (regime <<< es) + exponent;
  endfunction

endpackage

// File: rtl/posit_unpack_stage_pipe_reg.sv
// Generic valid/ready register slice carrying a payload of parameterised type T.
module posit_pipe_reg #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q, valid_d;
  T     data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/posit_unpack_stage.sv
// Two-stage posit64 unpack: decoded fields -> sign, scale, hidden-bit significand, sticky, flags.
// Define POSIT_UNPACK_SPECIAL_CNT_EN to add saturating zero/NaR output counters.
module posit_unpack_stage
  import posit_types::*;
#(
  parameter int unsigned ES      = 2,
  parameter int unsigned FRAC_W  = 59,
  parameter int unsigned SCALE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  posit64_t           in_p,
  input  sign_t              in_sign,
  input  logic [63:0]        in_regime,
  input  logic [63:0]        in_exponent,
  input  logic [63:0]        in_fraction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [SCALE_W-1:0] out_scale,
  output logic [FRAC_W:0]    out_sig,
  output logic               out_sticky,
  output logic               out_zero,
  output logic               out_nar
`ifdef POSIT_UNPACK_SPECIAL_CNT_EN
  ,
  output logic [31:0]        zero_cnt,
  output logic [31:0]        nar_cnt
`endif
);

  typedef struct packed {
    logic        sign;
    logic [63:0] regime;
    logic [63:0] exponent;
    logic [63:0] fraction;
    logic        zero;
    logic        nar;
  } s1_t;

  typedef struct packed {
    logic               sign;
    logic [SCALE_W-1:0] scale;
    logic [FRAC_W:0]    sig;
    logic               sticky;
    logic               zero;
    logic               nar;
  } s2_t;

  s1_t  s1_in, s1_out;
  s2_t  s2_in, s2_out;
  logic s1_valid, s2_in_ready;
  logic frac_sticky;

  always_comb begin
    s1_in          = '0;
    s1_in.sign     = in_sign;
    s1_in.regime   = in_regime;
    s1_in.exponent = in_exponent;
    s1_in.fraction = in_fraction;
    s1_in.zero     = (in_p == POSIT64_ZERO);
    s1_in.nar      = (in_p == POSIT64_NAR);
  end

  posit_pipe_reg #(.T(s1_t)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_ready(s2_in_ready),
    .out_data (s1_out)
  );

  if (FRAC_W < 64) begin : g_sticky
    assign frac_sticky = |s1_out.fraction[63-FRAC_W:0];
  end else begin : g_no_sticky
    assign frac_sticky = 1'b0;
  end

  // Special values ignore the decoder fields entirely.
  always_comb begin
    s2_in = '0;
    if (!(s1_out.zero || s1_out.nar)) begin
      s2_in.sign   = s1_out.sign;
      s2_in.scale  = SCALE_W'(posit_scale(s1_out.regime, s1_out.exponent, ES));
      s2_in.sig    = {1'b1, s1_out.fraction[63 -: FRAC_W]};
      s2_in.sticky = frac_sticky;
    end
    s2_in.zero = s1_out.zero;
    s2_in.nar  = s1_out.nar;
  end

  posit_pipe_reg #(.T(s2_t)) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s1_valid),
    .in_ready (s2_in_ready),
    .in_data  (s2_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_out)
  );

  assign out_sign   = s2_out.sign;
  assign out_scale  = s2_out.scale;
  assign out_sig    = s2_out.sig;
  assign out_sticky = s2_out.sticky;
  assign out_zero   = s2_out.zero;
  assign out_nar    = s2_out.nar;

`ifdef POSIT_UNPACK_SPECIAL_CNT_EN
  logic [31:0] zero_cnt_q, zero_cnt_d, nar_cnt_q, nar_cnt_d;
  logic        out_fire;

  assign out_fire = out_valid && out_ready;

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    nar_cnt_d  = nar_cnt_q;
    if (out_fire && out_zero && (zero_cnt_q != 32'hFFFF_FFFF)) zero_cnt_d = zero_cnt_q + 32'd1;
    if (out_fire && out_nar && (nar_cnt_q != 32'hFFFF_FFFF))   nar_cnt_d  = nar_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_q <= '0;
      nar_cnt_q  <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
      nar_cnt_q  <= nar_cnt_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
  assign nar_cnt  = nar_cnt_q;
`endif

endmodule

// File: tb/tb_posit_unpack_stage.sv
// Directed, table-driven bench for posit_unpack_stage (default config plus a FRAC_W=8 instance).
module tb_posit_unpack_stage;

  typedef struct {
    logic [63:0] p;
    logic        sign;
    logic [63:0] regime;
    logic [63:0] exponent;
    logic [63:0] fraction;
    logic        e_sign;
    logic [15:0] e_scale;
    logic [59:0] e_sig;
    logic        e_sticky;
    logic        e_zero;
    logic        e_nar;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_p, in_regime, in_exponent, in_fraction;
  logic        in_sign;
  logic        out_sign, out_sticky, out_zero, out_nar;
  logic [15:0] out_scale;
  logic [59:0] out_sig;
  logic [79:0] act80;

  logic        i8_valid, i8_ready, o8_valid, o8_sign, o8_sticky, o8_zero, o8_nar;
  logic [63:0] i8_fraction;
  logic [15:0] o8_scale;
  logic [8:0]  o8_sig;

`ifdef POSIT_UNPACK_SPECIAL_CNT_EN
  logic [31:0] zero_cnt, nar_cnt, zero_cnt8, nar_cnt8;
`endif

  int n_chk = 0;
  int n_fail = 0;

  posit_unpack_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_p       (in_p),
    .in_sign    (in_sign),
    .in_regime  (in_regime),
    .in_exponent(in_exponent),
    .in_fraction(in_fraction),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_scale  (out_scale),
    .out_sig    (out_sig),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_nar    (out_nar)
`ifdef POSIT_UNPACK_SPECIAL_CNT_EN
    ,
    .zero_cnt   (zero_cnt),
    .nar_cnt    (nar_cnt)
`endif
  );

  posit_unpack_stage #(.ES(2), .FRAC_W(8), .SCALE_W(16)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (i8_valid),
    .in_ready   (i8_ready),
    .in_p       (64'h4000_0000_0000_0000),
    .in_sign    (1'b0),
    .in_regime  (64'd0),
    .in_exponent(64'd0),
    .in_fraction(i8_fraction),
    .out_valid  (o8_valid),
    .out_ready  (1'b1),
    .out_sign   (o8_sign),
    .out_scale  (o8_scale),
    .out_sig    (o8_sig),
    .out_sticky (o8_sticky),
    .out_zero   (o8_zero),
    .out_nar    (o8_nar)
`ifdef POSIT_UNPACK_SPECIAL_CNT_EN
    ,
    .zero_cnt   (zero_cnt8),
    .nar_cnt    (nar_cnt8)
`endif
  );

  assign act80 = {out_sign, out_scale, out_sig, out_sticky, out_zero, out_nar};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] exp80(input vec_t v);
    return {v.e_sign, v.e_scale, v.e_sig, v.e_sticky, v.e_zero, v.e_nar};
  endfunction

  task automatic drive(input vec_t v);
    in_p        = v.p;
    in_sign     = v.sign;
    in_regime   = v.regime;
    in_exponent = v.exponent;
    in_fraction = v.fraction;
  endtask

  initial begin
    // {p, sign, regime, exponent, fraction, e_sign, e_scale, e_sig, e_sticky, e_zero, e_nar}
    vecs[0] = '{64'h4000_0000_0000_0000, 1'b0, 64'd0, 64'd0, 64'd0,
                1'b0, 16'h0000, 60'h800_0000_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'h6800_0000_0000_0000, 1'b0, 64'd1, 64'd1, 64'h8000_0000_0000_0000,
                1'b0, 16'h0005, 60'hC00_0000_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{64'hC000_0000_0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd0,
                1'b1, 16'hFFF6, 60'h800_0000_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'h7FFF_0000_0000_0000, 1'b0, 64'd62, 64'd3, 64'h0000_0000_0000_0010,
                1'b0, 16'h00FB, 60'h800_0000_0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_0003, 1'b0, 64'hFFFF_FFFF_FFFF_FFC2, 64'd0,
                64'h0000_0000_0000_0020,
                1'b0, 16'hFF08, 60'h800_0000_0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{64'h0000_0000_0000_0000, 1'b1, 64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b0, 16'h0000, 60'h0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFC2, 64'd1, 64'h1234,
                1'b0, 16'h0000, 60'h0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{64'h9000_0000_0000_0000, 1'b1, 64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
                1'b1, 16'h0003, 60'hFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    i8_valid    = 1'b0;
    i8_fraction = 64'd0;
    drive(vecs[0]);

    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out data", act80, 0);
    chk("reset in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Single transfers: latency and per-field results.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d out_valid after 1 cycle", i), out_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d out_valid after 2 cycles", i), out_valid, 1);
      chk($sformatf("vec%0d data", i), act80, exp80(vecs[i]));
    end

    // FRAC_W = 8: only the lowest fraction bit set -> all dropped into sticky.
    @(negedge clk);
    i8_fraction = 64'h0000_0000_0000_0001;
    i8_valid    = 1'b1;
    @(negedge clk);
    i8_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("fw8 out_valid", o8_valid, 1);
    chk("fw8 out_sig", o8_sig, 9'h100);
    chk("fw8 out_sticky", o8_sticky, 1);

    // Stream of 10 with out_ready pattern 1,0,0 repeating.
    begin
      int sent = 0;
      int got  = 0;
      int infl = 0;
      int cyc  = 0;
      int q[$];
      while (got < 10 && cyc < 200) begin
        @(negedge clk);
        out_ready = (cyc % 3 == 0);
        if (sent < 10) begin
          drive(vecs[sent % NV]);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        chk("stream in_ready", in_ready, !(infl == 2 && !out_ready));
        if (out_valid) begin
          if (q.size() > 0) chk("stream data", act80, exp80(vecs[q[0]]));
          else              chk("stream unexpected out_valid", out_valid, 0);
        end
        if (out_valid && out_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          got++;
          infl--;
        end
        if (in_valid && in_ready) begin
          q.push_back(sent % NV);
          sent++;
          infl++;
        end
        cyc++;
      end
      in_valid = 1'b0;
      chk("stream items received", got, 10);
      chk("stream items left in flight", q.size(), 0);
    end

    // Fill both stages, then reset mid-stream.
    @(negedge clk);
    out_ready = 1'b0;
    drive(vecs[1]);
    in_valid = 1'b1;
    @(negedge clk);
    drive(vecs[2]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full in_ready", in_ready, 0);
    chk("full out_valid", out_valid, 1);
    chk("full held data", act80, exp80(vecs[1]));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out data", act80, 0);
    chk("midreset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post-reset no stale out_valid", out_valid, 0);
    end

`ifdef POSIT_UNPACK_SPECIAL_CNT_EN
    chk("zero_cnt after reset", zero_cnt, 0);
    chk("nar_cnt after reset", nar_cnt, 0);
    begin
      int seq [6] = '{5, 5, 6, 5, 6, 0};
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        drive(vecs[seq[i]]);
        in_valid = 1'b1;
        #1;
        chk("cnt stream in_ready", in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("zero_cnt", zero_cnt, 3);
      chk("nar_cnt", nar_cnt, 2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
